// File: rtl/info_readout.sv
// info_readout: converts a 32-bit value into a scaled three-point-two digit
// readout with a prefix and unit glyph, and draws it as a pixel overlay.

// word: one 3x5 glyph cell anchored at (X0, Y0).
module word #(
    parameter int unsigned X0 = 0,
    parameter int unsigned Y0 = 0
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [4:0] code,
    output logic       pixel_c
);
    localparam int unsigned GW = 3;
    localparam int unsigned GH = 5;

    // Row-major bitmap, top row in the MSBs, left column first.
    function automatic logic [14:0] glyph(input logic [4:0] c);
        case (c)
            5'd0:    glyph = 15'b111_101_101_101_111;
            5'd1:    glyph = 15'b010_110_010_010_111;
            5'd2:    glyph = 15'b111_001_111_100_111;
            5'd3:    glyph = 15'b111_001_111_001_111;
            5'd4:    glyph = 15'b101_101_111_001_001;
            5'd5:    glyph = 15'b111_100_111_001_111;
            5'd6:    glyph = 15'b111_100_111_101_111;
            5'd7:    glyph = 15'b111_001_001_001_001;
            5'd8:    glyph = 15'b111_101_111_101_111;
            5'd9:    glyph = 15'b111_101_111_001_111;
            5'd10:   glyph = 15'b000_000_000_000_010;
            5'd11:   glyph = 15'b100_101_110_101_101;
            5'd13:   glyph = 15'b101_101_101_101_010;
            default: glyph = 15'b000_000_000_000_000;
        endcase
    endfunction

    logic [10:0] dx;
    logic [10:0] dy;
    logic [3:0]  idx;
    logic [15:0] bits;

    // Offset into the cell; negative offsets wrap high and fail the box test.
    always_comb begin
        dx      = {1'b0, x} - 11'(X0);
        dy      = {1'b0, y} - 11'(Y0);
        idx     = 4'(dy) * 4'd3 + 4'(dx);
        bits    = {1'b0, glyph(code)};
        pixel_c = (dx < 11'(GW)) && (dy < 11'(GH)) && bits[4'd14 - idx];
    end
endmodule

module info_readout #(
    parameter int unsigned OFFSET_X    = 0,
    parameter int unsigned OFFSET_Y    = 0,
    parameter int unsigned UNIT_CODE   = 13,
    parameter int unsigned CHAR_PITCH  = 7,
    parameter int unsigned HOLD_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  x_in,
    input  logic [9:0]  y_in,
    input  logic [31:0] number_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic        display
);
    localparam int unsigned SLOTS = 8;
    localparam int unsigned HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [4:0] C_POINT = 5'd10;
    localparam logic [4:0] C_KILO  = 5'd11;
    localparam logic [4:0] C_BASE  = 5'd12;
    localparam logic [4:0] C_BLANK = 5'd16;
    localparam logic [4:0] C_UNIT  = 5'(UNIT_CODE);
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT, HOLD} state_t;

    state_t        state;
    logic [1:0]    rst_sync;
    logic          rst_int_n;
    logic          pending;
    logic [31:0]   pend_val;
    logic [31:0]   bin_q;
    logic [39:0]   bcd_q;
    logic [35:0]   bcd_adj;
    logic [4:0]    bit_cnt;
    logic [HW-1:0] hold_cnt;
    logic [4:0]    hund_q, tens_q, ones_q, tenth_q, hundth_q, prefix_q;
    logic [3:0]    h, t, o, f1, f2;
    logic [4:0]    sel_hund_c, sel_tens_c, sel_prefix_c;
    logic          hold_exit_c, accept_c, start_c;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // Add-3 on d0..d8; d9 never exceeds 4 for a 32-bit operand.
    always_comb begin
        bcd_adj = bcd_q[35:0];
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Range select, saturation and leading-zero blanking of the finished BCD.
    always_comb begin
        h = bcd_q[11:8];
        t = bcd_q[7:4];
        o = bcd_q[3:0];
        f1 = 4'd0;
        f2 = 4'd0;
        sel_prefix_c = C_BASE;
        if (bcd_q[39:36] != 4'd0) begin
            h = 4'd9; t = 4'd9; o = 4'd9; f1 = 4'd9; f2 = 4'd9;
            sel_prefix_c = C_BLANK;
        end else if (bcd_q[35:24] != 12'd0) begin
            h = bcd_q[35:32]; t = bcd_q[31:28]; o = bcd_q[27:24];
            f1 = bcd_q[23:20]; f2 = bcd_q[19:16];
            sel_prefix_c = C_BLANK;
        end else if (bcd_q[23:12] != 12'd0) begin
            h = bcd_q[23:20]; t = bcd_q[19:16]; o = bcd_q[15:12];
            f1 = bcd_q[11:8]; f2 = bcd_q[7:4];
            sel_prefix_c = C_KILO;
        end
        sel_hund_c = (h == 4'd0) ? C_BLANK : {1'b0, h};
        sel_tens_c = (h == 4'd0 && t == 4'd0) ? C_BLANK : {1'b0, t};
    end

    // A new conversion may start from IDLE or on the last HOLD cycle.
    always_comb begin
        hold_exit_c = (state == HOLD) && (hold_cnt == '0);
        accept_c    = (state == IDLE) || hold_exit_c;
        start_c     = accept_c && (load || pending);
    end

    // Control FSM with conversion datapath and committed slot codes.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state    <= IDLE;
            pending  <= 1'b0;
            pend_val <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            bit_cnt  <= '0;
            hold_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hund_q   <= C_BLANK;
            tens_q   <= C_BLANK;
            ones_q   <= 5'd0;
            tenth_q  <= 5'd0;
            hundth_q <= 5'd0;
            prefix_q <= C_BASE;
        end else begin
            done <= 1'b0;
            if (start_c) begin
                bin_q   <= load ? number_in : pend_val;
                bcd_q   <= '0;
                bit_cnt <= '0;
                pending <= 1'b0;
                busy    <= 1'b1;
                state   <= CONV;
            end else begin
                case (state)
                    CONV: begin
                        bcd_q   <= {bcd_q[38:36], bcd_adj, bin_q[31]};
                        bin_q   <= {bin_q[30:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) state <= COMMIT;
                    end
                    COMMIT: begin
                        hund_q   <= sel_hund_c;
                        tens_q   <= sel_tens_c;
                        ones_q   <= {1'b0, o};
                        tenth_q  <= {1'b0, f1};
                        hundth_q <= {1'b0, f2};
                        prefix_q <= sel_prefix_c;
                        done     <= 1'b1;
                        if (HOLD_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - HW'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (load && !accept_c) begin
                pending  <= 1'b1;
                pend_val <= number_in;
            end
        end
    end

    logic [4:0]       slot_code [SLOTS];
    logic [SLOTS-1:0] slot_px;

    // Slot order: hundreds, tens, ones, point, tenths, hundredths, prefix, unit.
    always_comb begin
        slot_code[0] = hund_q;
        slot_code[1] = tens_q;
        slot_code[2] = ones_q;
        slot_code[3] = C_POINT;
        slot_code[4] = tenth_q;
        slot_code[5] = hundth_q;
        slot_code[6] = prefix_q;
        slot_code[7] = C_UNIT;
    end

    for (genvar n = 0; n < SLOTS; n++) begin : g_slot
        word #(
            .X0(OFFSET_X + n * CHAR_PITCH),
            .Y0(OFFSET_Y)
        ) u_word (
            .x      (x_in),
            .y      (y_in),
            .code   (slot_code[n]),
            .pixel_c(slot_px[n])
        );
    end

    assign display = |slot_px;
endmodule

// File: tb/tb_info_readout.sv
// tb_info_readout: scoreboard bench for the numeric glyph readout.
module tb_info_readout;
    logic        clk;
    logic        rst_n;
    logic [9:0]  x_in, y_in;
    logic [31:0] number_in;
    logic        load, load2;
    logic        busy, done, display;
    logic        busy2, done2, display2;

    int unsigned cyc = 0;
    int          tests = 0;
    int          failed = 0;
    int          done_seen = 0;

    typedef struct {
        logic [39:0] codes;
        int          due;
    } sb_t;
    sb_t sb[$];

    localparam logic [39:0] RESET_CODES = {5'd16, 5'd16, 5'd0, 5'd10, 5'd0, 5'd0, 5'd12, 5'd13};

    info_readout u_dut (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .number_in(number_in),
        .load(load), .busy(busy), .done(done), .display(display)
    );

    info_readout #(
        .OFFSET_X(100), .OFFSET_Y(50), .CHAR_PITCH(8), .HOLD_CYCLES(10)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .number_in(number_in),
        .load(load2), .busy(busy2), .done(done2), .display(display2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] font(input logic [4:0] c);
        case (c)
            5'd0:    font = 15'b111_101_101_101_111;
            5'd1:    font = 15'b010_110_010_010_111;
            5'd2:    font = 15'b111_001_111_100_111;
            5'd3:    font = 15'b111_001_111_001_111;
            5'd4:    font = 15'b101_101_111_001_001;
            5'd5:    font = 15'b111_100_111_001_111;
            5'd6:    font = 15'b111_100_111_101_111;
            5'd7:    font = 15'b111_001_001_001_001;
            5'd8:    font = 15'b111_101_111_101_111;
            5'd9:    font = 15'b111_101_111_001_111;
            5'd10:   font = 15'b000_000_000_000_010;
            5'd11:   font = 15'b100_101_110_101_101;
            5'd13:   font = 15'b101_101_101_101_010;
            default: font = 15'b0;
        endcase
    endfunction

    function automatic logic [119:0] exp_bm(input logic [39:0] codes);
        logic [119:0] bm;
        for (int n = 0; n < 8; n++) bm[119 - 15*n -: 15] = font(codes[39 - 5*n -: 5]);
        return bm;
    endfunction

    // Reference readout computed by decimal arithmetic.
    function automatic logic [39:0] model(input logic [31:0] v);
        longint unsigned nv, whole, frac;
        int h, t, o, f1, f2;
        logic [4:0] p, ch, ct;
        nv = longint'(v);
        if (nv >= 64'd1000000000) begin
            h = 9; t = 9; o = 9; f1 = 9; f2 = 9; p = 5'd16;
        end else begin
            if (nv < 64'd1000) begin
                whole = nv; frac = 0; p = 5'd12;
            end else if (nv < 64'd1000000) begin
                whole = nv / 1000; frac = (nv % 1000) / 10; p = 5'd11;
            end else begin
                whole = nv / 1000000; frac = (nv % 1000000) / 10000; p = 5'd16;
            end
            h  = int'(whole / 100);
            t  = int'((whole / 10) % 10);
            o  = int'(whole % 10);
            f1 = int'(frac / 10);
            f2 = int'(frac % 10);
        end
        ch = (h == 0) ? 5'd16 : 5'(h);
        ct = (h == 0 && t == 0) ? 5'd16 : 5'(t);
        return {ch, ct, 5'(o), 5'd10, 5'(f1), 5'(f2), p, 5'd13};
    endfunction

    // Scan every glyph cell of one readout and collect its bitmap.
    task automatic read_slots(input int ox, input int oy, input int pitch, input bit sel,
                              output logic [119:0] bm);
        for (int n = 0; n < 8; n++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 3; c++) begin
                    x_in = 10'(ox + n*pitch + c);
                    y_in = 10'(oy + r);
                    #1;
                    bm[119 - (n*15 + r*3 + c)] = sel ? display2 : display;
                end
        @(negedge clk);
    endtask

    // Called at a negedge; edge k samples the load.
    task automatic do_load(input logic [31:0] v, output int k);
        number_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = int'(cyc);
    endtask

    // Wait for a done pulse, pop the scoreboard and compare.
    task automatic wait_done(input string name);
        sb_t e;
        int n;
        logic [119:0] bm;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (done !== 1'b1) begin
            failed++;
            $display("FAIL %s done: no pulse within 200 cycles", name);
            return;
        end
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $display("FAIL %s scoreboard: done with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        if (e.due != 0) begin
            tests++;
            if (int'(cyc) != e.due) begin
                failed++;
                $display("FAIL %s latency: done at edge %0d, expected %0d", name, cyc, e.due);
            end
        end
        tests++;
        if (busy !== 1'b0) begin
            failed++;
            $display("FAIL %s busy_after_commit: got %b expected 0", name, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            failed++;
            $display("FAIL %s done_width: done still %b after one cycle", name, done);
        end
        read_slots(0, 0, 7, 1'b0, bm);
        tests++;
        if (bm !== exp_bm(e.codes)) begin
            failed++;
            $display("FAIL %s display: got %h expected %h", name, bm, exp_bm(e.codes));
        end
    endtask

    task automatic test_reset;
        logic [119:0] bm;
        rst_n = 1'b0; load = 1'b0; load2 = 1'b0; number_in = '0; x_in = '0; y_in = '0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || busy2 !== 1'b0 || done2 !== 1'b0) begin
            failed++;
            $display("FAIL reset_flags: busy=%b done=%b busy2=%b done2=%b expected 0", busy, done, busy2, done2);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_slots(0, 0, 7, 1'b0, bm);
        tests++;
        if (bm !== exp_bm(RESET_CODES)) begin
            failed++;
            $display("FAIL reset_display: got %h expected %h", bm, exp_bm(RESET_CODES));
        end
        read_slots(100, 50, 8, 1'b1, bm);
        tests++;
        if (bm !== exp_bm(RESET_CODES)) begin
            failed++;
            $display("FAIL reset_display2: got %h expected %h", bm, exp_bm(RESET_CODES));
        end
    endtask

    task automatic test_values;
        logic [31:0] vals [11];
        int k;
        vals = '{32'd1234, 32'd7, 32'd0, 32'd999999, 32'd1000000, 32'hFFFF_FFFF,
                 32'd999, 32'd1000, 32'd123456789, 32'd999999999, 32'd1000000000};
        foreach (vals[i]) begin
            do_load(vals[i], k);
            sb.push_back('{model(vals[i]), k + 33});
            tests++;
            if (busy !== 1'b1) begin
                failed++;
                $display("FAIL value %0d busy_start: got %b expected 1", vals[i], busy);
            end
            wait_done($sformatf("value %0d", vals[i]));
        end
    endtask

    // Newer pending loads overwrite older ones; only 5 and 8 commit.
    task automatic test_pending;
        int k, k2, base;
        base = done_seen;
        do_load(32'd5, k);
        sb.push_back('{model(32'd5), k + 33});
        repeat (2) @(negedge clk);
        do_load(32'd6, k2);
        repeat (4) @(negedge clk);
        do_load(32'd8, k2);
        sb.push_back('{model(32'd8), k + 67});
        wait_done("pending first");
        wait_done("pending second");
        repeat (45) @(negedge clk);
        tests++;
        if (done_seen - base != 2) begin
            failed++;
            $display("FAIL pending_count: %0d commits, expected 2", done_seen - base);
        end
    endtask

    // A load coinciding with COMMIT is kept and converted next.
    task automatic test_back_to_back;
        int k, k2;
        do_load(32'd42, k);
        sb.push_back('{model(32'd42), k + 33});
        repeat (32) @(negedge clk);
        do_load(32'd56789, k2);
        sb.push_back('{model(32'd56789), k + 67});
        wait_done("b2b commit_edge_first");
        wait_done("b2b commit_edge_second");
    endtask

    task automatic test_hold;
        int k, n, d1, d2;
        logic [119:0] bm;
        number_in = 32'd42; load2 = 1'b1;
        @(negedge clk);
        k = int'(cyc);
        number_in = 32'd1234;
        @(negedge clk);
        load2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        d1 = int'(cyc);
        tests++;
        if (done2 !== 1'b1 || d1 != k + 33) begin
            failed++;
            $display("FAIL hold first_done: done2=%b at edge %0d, expected edge %0d", done2, d1, k + 33);
        end
        tests++;
        if (busy2 !== 1'b1) begin
            failed++;
            $display("FAIL hold busy_in_hold: got %b expected 1", busy2);
        end
        @(negedge clk);
        read_slots(100, 50, 8, 1'b1, bm);
        tests++;
        if (bm !== exp_bm(model(32'd42))) begin
            failed++;
            $display("FAIL hold display_first: got %h expected %h", bm, exp_bm(model(32'd42)));
        end
        n = 0;
        while (done2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        d2 = int'(cyc);
        tests++;
        if (done2 !== 1'b1 || d2 - d1 != 43) begin
            failed++;
            $display("FAIL hold gap: done2=%b gap %0d cycles, expected 43", done2, d2 - d1);
        end
        @(negedge clk);
        read_slots(100, 50, 8, 1'b1, bm);
        tests++;
        if (bm !== exp_bm(model(32'd1234))) begin
            failed++;
            $display("FAIL hold display_second: got %h expected %h", bm, exp_bm(model(32'd1234)));
        end
    endtask

    task automatic test_reset_conv;
        int k, base;
        logic [119:0] bm;
        do_load(32'd777, k);
        do_load(32'd555, k);
        repeat (13) @(negedge clk);
        base = done_seen;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL reset_conv flags: busy=%b done=%b expected 0 0", busy, done);
        end
        read_slots(0, 0, 7, 1'b0, bm);
        tests++;
        if (bm !== exp_bm(RESET_CODES)) begin
            failed++;
            $display("FAIL reset_conv display: got %h expected %h", bm, exp_bm(RESET_CODES));
        end
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        tests++;
        if (done_seen != base || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_conv abandon: %0d commits busy=%b, expected 0 commits busy 0",
                     done_seen - base, busy);
        end
        do_load(32'd321, k);
        sb.push_back('{model(32'd321), k + 33});
        wait_done("after_reset");
    endtask

    initial begin
        test_reset();
        test_values();
        test_pending();
        test_back_to_back();
        test_hold();
        test_reset_conv();
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/info_readout.md
INFO_READOUT -- requirements
Module: info_readout

Interface
REQ-001 The block SHALL have the parameter OFFSET_X, default 0, giving the left pixel column of the readout.
REQ-002 The block SHALL have the parameter OFFSET_Y, default 0, giving the top pixel row of the readout.
REQ-003 The block SHALL have the parameter UNIT_CODE, default 13, giving the 5-bit glyph code of the unit character.
REQ-004 The block SHALL have the parameter CHAR_PITCH, default 7, giving the horizontal pixel spacing between glyph slots.
REQ-005 The block SHALL have the parameter HOLD_CYCLES, default 0, giving the minimum idle cycles between display commits (rate limit).
REQ-006 The block SHALL have the port clk, input, 1 bit: system clock, single clock domain.
REQ-007 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The block SHALL have the port x_in, input, 10 bits: current pixel column.
REQ-009 The block SHALL have the port y_in, input, 10 bits: current pixel row.
REQ-010 The block SHALL have the port number_in, input, 32 bits: unsigned value to display, sampled on load.
REQ-011 The block SHALL have the port load, input, 1 bit: single-cycle request to convert number_in.
REQ-012 The block SHALL have the port busy, output, 1 bit: high while not IDLE.
REQ-013 The block SHALL have the port done, output, 1 bit: one-cycle pulse when new digits are committed.
REQ-014 The block SHALL have the port display, output, 1 bit: pixel lit at (x_in, y_in).

Function
REQ-015 Glyph codes SHALL be: 0-9 digits, 10 decimal point, 11 kilo prefix, 12 base prefix, 16 blank.
REQ-016 The layout SHALL be eight slots at x = OFFSET_X + n*CHAR_PITCH, n = 0..7: hundreds, tens, ones, point, tenths, hundredths, prefix, unit; all slots at row OFFSET_Y.
REQ-017 Each slot SHALL be drawn by one existing Word glyph instance; display SHALL be the OR of all slot outputs and SHALL be combinational from x_in/y_in and the committed-digit register only.
REQ-018 The FSM SHALL have states IDLE, CONV, COMMIT and HOLD.
REQ-019 In IDLE with load or pending set, the FSM SHALL capture the operand (load value takes priority) into a shift register, clear pending and go to CONV.
REQ-020 CONV SHALL run a shift-and-add-3 binary-to-BCD conversion to 10 BCD digits d9..d0, one bit per cycle, for exactly 32 cycles, then go to COMMIT.
REQ-021 In the range N < 1000, COMMIT SHALL select digits d2 d1 d0 . 0 0 with prefix 12.
REQ-022 In the range 1000 <= N < 1000000, COMMIT SHALL select digits d5 d4 d3 . d2 d1 with prefix 11.
REQ-023 In the range N >= 1000000, COMMIT SHALL select digits d8 d7 d6 . d5 d4 with prefix 16; digits are truncated, not rounded.
REQ-024 For N >= 1000000000, COMMIT SHALL saturate to 9 9 9 . 9 9 with prefix 16.
REQ-025 Leading-zero blanking: hundreds SHALL show 16 if zero; tens SHALL show 16 if hundreds and tens are both zero; ones SHALL never be blanked.
REQ-026 COMMIT SHALL update all slot codes atomically in one edge and pulse done high for that one cycle.
REQ-027 After COMMIT the FSM SHALL go to HOLD for HOLD_CYCLES cycles, then to IDLE; with HOLD_CYCLES = 0 it SHALL go directly to IDLE.
REQ-028 Latency: for a load sampled at edge k from IDLE, the digits and done SHALL change at edge k+33.
REQ-029 A load arriving in CONV, COMMIT or HOLD SHALL set pending and store number_in, overwriting any earlier pending value (depth 1, newest wins).
REQ-030 A load in the same cycle as COMMIT SHALL be captured as pending.
REQ-031 busy SHALL be low only in IDLE.

Reset
REQ-032 Asserting rst_n low SHALL immediately set the state to IDLE, clear pending, busy, done and the hold counter, and set the slot codes to 16 16 0 . 0 0 12 UNIT_CODE.
REQ-033 Reset during CONV SHALL abandon the conversion without any commit.
REQ-034 Reset SHALL be asynchronously asserted and synchronously released.

Verification
REQ-035 Load 1234 -> done at load edge +33; slots show blank 1 . 2 3 with prefix 11, i.e. "  1.23k".
REQ-036 Load 7 -> "  7.00" with prefix 12; load 0 -> "  0.00"; load 999999 -> "999.99k"; load 1000000 -> "  1.00" with prefix 16.
REQ-037 Load 4294967295 -> "999.99" with prefix 16 (saturation).
REQ-038 Load 5, then loads 6 and 8 during CONV -> first commit shows 5, second commit shows 8, no commit of 6.
REQ-039 HOLD_CYCLES = 10: two back-to-back loads -> the second done occurs exactly 10 + 33 cycles after the first.
REQ-040 rst_n low at CONV cycle 15 -> no done pulse, slot codes return to the reset pattern, busy low; a subsequent load converts correctly.
